// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the datapath load/store path: one access per
// strobe assertion, programmable wait states, registered data/ready/fault outputs.
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        busy,
  output logic        err
);

  // state | meaning
  // IDLE  | accepting a new read/write request
  // WAIT  | counting down wait states for the latched access
  // DONE  | access performed last edge; mem_ready pulse cycle
  // HOLD  | access finished, waiting for both strobes to drop

  typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_t;

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  state_t      state;
  op_t         op_q;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        bad_q;

  logic [31:0] mem [DEPTH];

  op_t                   acc_op;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic                  acc_bad;
  logic                  acc_range;
  logic                  acc_fault;
  logic                  enter_done;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] idx;

  // With zero wait states the access happens on the accepting edge, so the
  // live inputs are used in IDLE and the latched copies everywhere else.
  always_comb begin
    acc_op    = op_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_bad   = bad_q;
    if (state == IDLE) begin
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_bad   = read & write;
      if (read & ~write)
        acc_op = OP_READ;
      else if (write & ~read)
        acc_op = OP_WRITE;
      else
        acc_op = OP_NONE;
    end
    acc_range  = |acc_addr[31:ADDR_WIDTH];
    acc_fault  = acc_bad | acc_range;
    idx        = acc_addr[ADDR_WIDTH-1:0];
    enter_done = 1'b0;
    if (state == IDLE)
      enter_done = (read & write) | ((read ^ write) & (WS == 4'd0));
    else if (state == WAIT)
      enter_done = (cnt == 4'd1);
    ram_we = enter_done & (acc_op == OP_WRITE) & ~acc_fault;
  end

  // Gated by clr so a strobe held through reset can never commit a write.
  always_ff @(posedge clk) begin
    if (ram_we && clr)
      mem[idx] <= acc_wdata;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      op_q      <= OP_NONE;
      cnt       <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bad_q     <= 1'b0;
      rdata     <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_ready <= enter_done;
      err       <= enter_done & acc_fault;
      if (enter_done && acc_op == OP_READ)
        rdata <= acc_range ? 32'd0 : mem[idx];

      case (state)
        IDLE: begin
          if (read | write) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            bad_q   <= read & write;
            op_q    <= acc_op;
            cnt     <= WS;
            busy    <= 1'b1;
            state   <= enter_done ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= DONE;
        end
        DONE: begin
          if (read | write) begin
            state <= HOLD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        HOLD: begin
          if (!(read | write)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_STATES=2 and a WAIT_STATES=0 instance
// share the request inputs; table-driven accesses plus reset and back-to-back sequences.
module tb_mem_responder;

  logic        clk;
  logic        clr;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata2, rdata0;
  logic        mem_ready2, mem_ready0;
  logic        busy2, busy0;
  logic        err2, err0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(.ADDR_WIDTH(9), .WAIT_STATES(2)) dut2 (
    .clk(clk), .clr(clr), .read(read), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .mem_ready(mem_ready2), .busy(busy2), .err(err2)
  );

  mem_responder #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dut0 (
    .clk(clk), .clr(clr), .read(read), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .mem_ready(mem_ready0), .busy(busy0), .err(err0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request on the WAIT_STATES=2 instance and observes 12 cycles.
  task automatic run_vec(input vec_t v, input string tag);
    int          lat;
    int          pulses;
    logic [31:0] r;
    logic        e;
    @(negedge clk);
    read  = v.rd;
    write = v.wr;
    addr  = v.addr;
    wdata = v.wdata;
    lat = 0; pulses = 0; r = '0; e = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_ready2 === 1'b1) begin
        pulses++;
        if (lat == 0) begin
          lat = i + 1;
          r   = rdata2;
          e   = err2;
        end
      end
      if (i == v.hold - 1) begin
        read  = 1'b0;
        write = 1'b0;
        addr  = 32'hFFFF_FFFF;
        wdata = 32'h0;
      end
    end
    check({tag, " pulses"}, 32'(pulses), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, " rdata"}, r, v.exp_rdata);
    check({tag, " err"}, {31'd0, e}, {31'd0, v.exp_err});
    check({tag, " busy after"}, {31'd0, busy2}, 32'd0);
  endtask

  initial begin
    vec_t v;
    //            rd    wr    addr          wdata          hold exp_rdata      err  lat
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 6, 32'h0000_0000, 1'b0, 3};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 6, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 2, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 6, 32'h0000_0000, 1'b1, 3};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0001, 6, 32'h0000_0000, 1'b1, 3};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1, 32'hA5A5_A5A5, 1'b0, 3};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0007, 32'h7777_7777, 6, 32'hA5A5_A5A5, 1'b0, 3};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0007, 32'h0000_0BAD, 6, 32'hA5A5_A5A5, 1'b1, 1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0007, 32'h0000_0000, 6, 32'h7777_7777, 1'b0, 3};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_01FF, 32'h0000_FFFF, 3, 32'h7777_7777, 1'b0, 3};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_01FF, 32'h0000_0000, 6, 32'h0000_FFFF, 1'b0, 3};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0001, 32'h1111_1111, 6, 32'h0000_FFFF, 1'b0, 3};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0002, 32'h2222_2222, 6, 32'h0000_FFFF, 1'b0, 3};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0001, 32'h0000_0000, 6, 32'h1111_1111, 1'b0, 3};
    vecs[14] = '{1'b0, 1'b1, 32'h0000_000A, 32'hCAFE_F00D, 6, 32'h1111_1111, 1'b0, 3};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_000A, 32'h0000_0000, 6, 32'hCAFE_F00D, 1'b0, 3};

    clr = 1'b1; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;

    // Mid-cycle reset with no clock edge in between
    #12 clr = 1'b0;
    #1;
    check("reset rdata", rdata2, 32'h0);
    check("reset mem_ready", {31'd0, mem_ready2}, 32'd0);
    check("reset busy", {31'd0, busy2}, 32'd0);
    check("reset err", {31'd0, err2}, 32'd0);
    check("reset rdata ws0", rdata0, 32'h0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("post-reset busy", {31'd0, busy2}, 32'd0);

    for (int k = 0; k < 16; k++)
      run_vec(vecs[k], $sformatf("vec%0d", k));

    // Reset during WAIT of a write: must not commit
    @(negedge clk);
    write = 1'b1; addr = 32'h0000_000A; wdata = 32'h1234_5678;
    @(posedge clk);
    #2;
    check("wait busy before reset", {31'd0, busy2}, 32'd1);
    clr = 1'b0;
    #1;
    check("midwait rdata", rdata2, 32'h0);
    check("midwait busy", {31'd0, busy2}, 32'd0);
    check("midwait mem_ready", {31'd0, mem_ready2}, 32'd0);
    check("midwait err", {31'd0, err2}, 32'd0);
    @(negedge clk);
    write = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    v = '{1'b1, 1'b0, 32'h0000_000A, 32'h0, 6, 32'hCAFE_F00D, 1'b0, 3};
    run_vec(v, "read after aborted write");

    // WAIT_STATES=0 back-to-back reads, one idle edge between
    @(negedge clk);
    read = 1'b1; addr = 32'h0000_0001;
    @(negedge clk);
    check("ws0 first ready", {31'd0, mem_ready0}, 32'd1);
    check("ws0 first rdata", rdata0, 32'h1111_1111);
    check("ws0 first err", {31'd0, err0}, 32'd0);
    read = 1'b0; addr = 32'hFFFF_FFFF;
    @(negedge clk);
    check("ws0 gap ready", {31'd0, mem_ready0}, 32'd0);
    check("ws0 gap busy", {31'd0, busy0}, 32'd0);
    read = 1'b1; addr = 32'h0000_0002;
    @(negedge clk);
    check("ws0 second ready", {31'd0, mem_ready0}, 32'd1);
    check("ws0 second rdata", rdata0, 32'h2222_2222);
    @(negedge clk);
    check("ws0 held no repeat", {31'd0, mem_ready0}, 32'd0);
    check("ws0 held busy", {31'd0, busy0}, 32'd1);
    read = 1'b0; addr = '0;
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
